// File: rtl/bsg_axil_pkg.sv
// Shared AXI4-lite definitions: response codes and the CSR responder FSM states.
package bsg_axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } axil_w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } axil_r_state_e;

endpackage

// File: rtl/bsg_axil_csr_responder.sv
// AXI4-lite slave exposing num_regs_p byte-writable CSRs; independent read and
// write FSMs, one outstanding transaction per direction.
module bsg_axil_csr_responder
  import bsg_axil_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32,
  parameter int num_regs_p   = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  input  logic [addr_width_p-1:0]            awaddr_i,
  input  logic [2:0]                         awprot_i,
  input  logic                               awvalid_i,
  output logic                               awready_o,

  input  logic [data_width_p-1:0]            wdata_i,
  input  logic [data_width_p/8-1:0]          wstrb_i,
  input  logic                               wvalid_i,
  output logic                               wready_o,

  output logic [1:0]                         bresp_o,
  output logic                               bvalid_o,
  input  logic                               bready_i,

  input  logic [addr_width_p-1:0]            araddr_i,
  input  logic [2:0]                         arprot_i,
  input  logic                               arvalid_i,
  output logic                               arready_o,

  output logic [data_width_p-1:0]            rdata_o,
  output logic [1:0]                         rresp_o,
  output logic                               rvalid_o,
  input  logic                               rready_i,

  output logic [num_regs_p*data_width_p-1:0] csr_o,
  output logic [num_regs_p-1:0]              csr_w_v_o
);

  localparam int bytes_lp       = data_width_p / 8;
  localparam int lg_bytes_lp    = $clog2(bytes_lp);
  localparam int lg_regs_lp     = $clog2(num_regs_p);
  localparam int range_shift_lp = lg_bytes_lp + lg_regs_lp;

  // Protection bits carry no meaning for this block.
  logic unused_prot;
  assign unused_prot = ^{awprot_i, arprot_i};

  logic [num_regs_p-1:0][data_width_p-1:0] csr_values;
  assign csr_o = csr_values;

  // ---------------- write path ----------------
  axil_w_state_e w_state_reg, w_state_next;
  logic [addr_width_p-1:0]   awaddr_reg;
  logic [data_width_p-1:0]   wdata_reg;
  logic [bytes_lp-1:0]       wstrb_reg;
  logic [1:0]                bresp_reg;
  logic [num_regs_p-1:0]     csr_w_v_reg;

  logic                      aw_hs, w_hs, commit_en, commit_in_range;
  logic [addr_width_p-1:0]   commit_addr;
  logic [data_width_p-1:0]   commit_data;
  logic [bytes_lp-1:0]       commit_strb;
  logic [lg_regs_lp-1:0]     commit_index;

  assign aw_hs = awvalid_i & awready_o;
  assign w_hs  = wvalid_i & wready_o;

  always_comb begin
    w_state_next = w_state_reg;
    awready_o    = 1'b0;
    wready_o     = 1'b0;
    bvalid_o     = 1'b0;
    commit_en    = 1'b0;
    unique case (w_state_reg)
      W_IDLE: begin
        awready_o = ~reset_i;
        wready_o  = ~reset_i;
        if (aw_hs && w_hs) begin
          w_state_next = W_RESP;
          commit_en    = 1'b1;
        end else if (aw_hs) begin
          w_state_next = W_HAVE_AW;
        end else if (w_hs) begin
          w_state_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        wready_o = ~reset_i;
        if (w_hs) begin
          w_state_next = W_RESP;
          commit_en    = 1'b1;
        end
      end
      W_HAVE_W: begin
        awready_o = ~reset_i;
        if (aw_hs) begin
          w_state_next = W_RESP;
          commit_en    = 1'b1;
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // The completing handshake's payload comes straight from the ports; the
  // earlier one comes from the capture registers.
  assign commit_addr     = (w_state_reg == W_HAVE_AW) ? awaddr_reg : awaddr_i;
  assign commit_data     = (w_state_reg == W_HAVE_W)  ? wdata_reg  : wdata_i;
  assign commit_strb     = (w_state_reg == W_HAVE_W)  ? wstrb_reg  : wstrb_i;
  assign commit_index    = commit_addr[lg_bytes_lp +: lg_regs_lp];
  assign commit_in_range = ((commit_addr >> range_shift_lp) == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_state_reg <= W_IDLE;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      bresp_reg   <= AXIL_RESP_OKAY;
      csr_w_v_reg <= '0;
    end else begin
      w_state_reg <= w_state_next;
      csr_w_v_reg <= '0;
      if (aw_hs) awaddr_reg <= awaddr_i;
      if (w_hs) begin
        wdata_reg <= wdata_i;
        wstrb_reg <= wstrb_i;
      end
      if (commit_en) begin
        bresp_reg <= commit_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        if (commit_in_range) csr_w_v_reg[commit_index] <= 1'b1;
      end
    end
  end

  assign bresp_o   = bresp_reg;
  assign csr_w_v_o = csr_w_v_reg;

  genvar gi;
  generate
    for (gi = 0; gi < num_regs_p; gi++) begin : g_csr
      logic [data_width_p-1:0] value_reg;
      logic                    hit;

      assign hit = commit_en && commit_in_range && (commit_index == lg_regs_lp'(gi));

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          value_reg <= '0;
        end else if (hit) begin
          for (int b = 0; b < bytes_lp; b++) begin
            if (commit_strb[b]) value_reg[b*8 +: 8] <= commit_data[b*8 +: 8];
          end
        end
      end

      assign csr_values[gi] = value_reg;
    end
  endgenerate

  // ---------------- read path ----------------
  axil_r_state_e r_state_reg, r_state_next;
  logic [data_width_p-1:0] rdata_reg;
  logic [1:0]              rresp_reg;
  logic                    ar_hs, ar_in_range;
  logic [lg_regs_lp-1:0]   ar_index;

  assign ar_hs       = arvalid_i & arready_o;
  assign ar_index    = araddr_i[lg_bytes_lp +: lg_regs_lp];
  assign ar_in_range = ((araddr_i >> range_shift_lp) == '0);

  always_comb begin
    r_state_next = r_state_reg;
    arready_o    = 1'b0;
    rvalid_o     = 1'b0;
    unique case (r_state_reg)
      R_IDLE: begin
        arready_o = ~reset_i;
        if (ar_hs) r_state_next = R_RESP;
      end
      R_RESP: begin
        rvalid_o = 1'b1;
        if (rready_i) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state_reg <= R_IDLE;
      rdata_reg   <= '0;
      rresp_reg   <= AXIL_RESP_OKAY;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_hs) begin
        rdata_reg <= ar_in_range ? csr_values[ar_index] : '0;
        rresp_reg <= ar_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      end
    end
  end

  assign rdata_o = rdata_reg;
  assign rresp_o = rresp_reg;

endmodule

// File: doc/bsg_axil_csr_responder.md
BSG_AXIL_CSR_RESPONDER -- requirements
Module: bsg_axil_csr_responder

Interface
REQ-001 SHALL have parameter addr_width_p, default 10, meaning AXI4-lite address width.
REQ-002 SHALL have parameter data_width_p, default 32, meaning AXI4-lite data width (32 or 64).
REQ-003 SHALL have parameter num_regs_p, default 8, meaning CSR count (power of two, >=2).
REQ-004 SHALL have ports clk_i (in, 1, sole clock) and reset_i (in, 1), where reset_i is synchronous and active-high.
REQ-005 SHALL have AW-channel ports: awaddr_i (in, addr_width_p), awprot_i (in, 3, ignored), awvalid_i (in, 1), awready_o (out, 1).
REQ-006 SHALL have W-channel ports: wdata_i (in, data_width_p), wstrb_i (in, data_width_p/8), wvalid_i (in, 1), wready_o (out, 1).
REQ-007 SHALL have B-channel ports: bresp_o (out, 2), bvalid_o (out, 1), bready_i (in, 1).
REQ-008 SHALL have AR-channel ports: araddr_i (in, addr_width_p), arprot_i (in, 3, ignored), arvalid_i (in, 1), arready_o (out, 1).
REQ-009 SHALL have R-channel ports: rdata_o (out, data_width_p), rresp_o (out, 2), rvalid_o (out, 1), rready_i (in, 1).
REQ-010 SHALL have CSR ports: csr_o (out, num_regs_p*data_width_p, current register values, reg k in slice k), and csr_w_v_o (out, num_regs_p, one-cycle pulse per register written).

Function
REQ-011 SHALL decode index = addr[lg(bytes)+lg(num_regs_p)-1 : lg(bytes)], where bytes = data_width_p/8, and SHALL ignore the low lg(bytes) address bits.
REQ-012 SHALL treat an address >= num_regs_p*bytes as out of range, returning SLVERR (2'b10); in-range accesses return OKAY (2'b00).
REQ-013 SHALL implement a write FSM with states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-014 SHALL assert awready_o in W_IDLE and W_HAVE_W, and wready_o in W_IDLE and W_HAVE_AW; both are deasserted in W_RESP.
REQ-015 SHALL transition W_IDLE to W_HAVE_AW on AW handshake only, to W_HAVE_W on W handshake only, and to W_RESP on both handshakes in the same cycle; each channel's payload is captured at its handshake.
REQ-016 SHALL, on entry to W_RESP, commit the write in that same clock edge: per-byte update where wstrb is set, csr_w_v_o[index] pulsed for exactly one cycle, and no update or pulse when out of range.
REQ-017 SHALL assert bvalid_o in W_RESP (latency of 1 cycle after the completing handshake) and hold bresp_o stable until bready_i; on the handshake, return to W_IDLE.
REQ-018 SHALL pulse csr_w_v_o even when wstrb_i is all zero (in range), while leaving the data unchanged.
REQ-019 SHALL implement a read FSM with states R_IDLE and R_RESP, with arready_o asserted only in R_IDLE.
REQ-020 SHALL, on AR handshake, register rdata_o from register values before that edge (0 if out of range) and enter R_RESP with rvalid_o=1 on the next cycle.
REQ-021 SHALL hold rdata_o and rresp_o stable while rvalid_o=1 and !rready_i, and return to R_IDLE on the R handshake.
REQ-022 SHALL run the read and write FSMs independently; if a read and a write commit to the same register in the same cycle, the read returns the old value.
REQ-023 SHALL allow at most one outstanding transaction per direction; no new AR is accepted in the R handshake cycle (one bubble).

Reset
REQ-024 SHALL, on reset_i=1 at a clock edge, put both FSMs in IDLE and drive all CSRs, rdata_o, bresp_o, rresp_o and csr_w_v_o to 0, with bvalid_o=rvalid_o=0.
REQ-025 SHALL assert awready_o, wready_o and arready_o as 0 while reset_i=1.
REQ-026 SHALL, when reset is asserted mid-transaction, drop all pending state and captured payloads without committing a write or producing a response.

Structure
REQ-027 SHALL place the AXI response codes (OKAY=2'b00, SLVERR=2'b10) and the write/read FSM state enums in the shared package bsg_axil_pkg.
REQ-028 SHALL have no sub-module other than standard bsg primitives; the byte-masked register update is inline.

Verification
REQ-029 SHALL verify: after reset, AW 0x004 and W 0xDEADBEEF with strb 4'hF in the same cycle -> bvalid 1 cycle later with OKAY, csr_o reg1=0xDEADBEEF, and csr_w_v_o=8'b0000_0010 for one cycle.
REQ-030 SHALL verify: W 0x000000AA with strb 4'b0001 given 3 cycles before AW 0x008, where reg2 was 0x11223344 -> reg2=0x112233AA, with bvalid only after AW.
REQ-031 SHALL verify: AR 0x004 after REQ-029 with rready held low for 5 cycles -> rvalid with rdata=0xDEADBEEF stable for all 5 cycles, then R handshake completes.
REQ-032 SHALL verify: write to 0x040 and read of 0x100 -> SLVERR on both, rdata=0, and csr_o and csr_w_v_o unchanged.
REQ-033 SHALL verify: simultaneous AR and AW/W to 0x00C, where reg3=5, new data=9 -> rdata=5 and reg3=9 afterward.
REQ-034 SHALL verify: reset asserted while in W_HAVE_AW -> after release, a lone W is not committed and all CSRs are 0.
